// File: rtl/valve_sequencer.sv
// valve_sequencer: fetches 21-bit instructions from an asynchronous-read
// memory and executes SET / DELAY / HALT to drive a 16-bit valve bank.
// Each instruction is fetched in one cycle and executed in the next. DELAY
// waits are timed with a prescaler and a 10-bit count, so no multiplier is
// needed and 1023 ms cannot overflow.
module valve_sequencer #(
    parameter int unsigned CLKS_PER_MS = 100000,
    parameter logic [7:0]  START_ADDR  = 8'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [7:0]  inst_addr,
    input  logic [20:0] inst_data,
    output logic [15:0] valves,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WAIT,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [2:0]  OP_HALT    = 3'b000;
    localparam logic [2:0]  OP_SET     = 3'b001;
    localparam logic [2:0]  OP_DELAY   = 3'b010;
    localparam logic [2:0]  UNIT_CYCLE = 3'b000;
    localparam logic [2:0]  UNIT_MS    = 3'b001;
    localparam logic [31:0] PRE_MS     = CLKS_PER_MS - 1;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  pc;
    logic [20:0] ir;
    logic [9:0]  wait_cnt;
    logic [31:0] pre_cnt;
    logic [31:0] pre_reload;

    // Strobes from the next-state logic into the datapath.
    logic pc_load;
    logic pc_inc;
    logic ir_load;
    logic valve_wr;
    logic wait_load;

    // Instruction register fields.
    logic [2:0] ir_op;
    logic [3:0] ir_idx;
    logic       ir_val;
    logic [9:0] ir_cnt;
    logic [2:0] ir_unit;
    logic       unit_ok;

    assign ir_op   = ir[20:18];
    assign ir_idx  = ir[17:14];
    assign ir_val  = ir[0];
    assign ir_cnt  = ir[13:4];
    assign ir_unit = ir[3:1];
    assign unit_ok = (ir_unit == UNIT_CYCLE) || (ir_unit == UNIT_MS);

    // One prescaler period per count tick: 1 cycle for cycle units, a
    // millisecond for ms units. The unit stays in ir for the whole WAIT.
    assign pre_reload = (ir_unit == UNIT_MS) ? PRE_MS : 32'd0;

    assign inst_addr = pc;

    // State register; reset forces IDLE at once, even mid-WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode, datapath strobes and status outputs.
    always_comb begin
        state_nxt = state;
        pc_load   = 1'b0;
        pc_inc    = 1'b0;
        ir_load   = 1'b0;
        valve_wr  = 1'b0;
        wait_load = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                done  = (state == S_DONE);
                error = (state == S_ERROR);
                if (start) begin
                    pc_load   = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                busy      = 1'b1;
                ir_load   = 1'b1;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                busy = 1'b1;
                case (ir_op)
                    OP_HALT: state_nxt = S_DONE;
                    OP_SET: begin
                        valve_wr  = 1'b1;
                        pc_inc    = 1'b1;
                        state_nxt = S_FETCH;
                    end
                    OP_DELAY: begin
                        // An illegal unit is an error even with a zero count.
                        if (!unit_ok) begin
                            state_nxt = S_ERROR;
                        end else if (ir_cnt == 10'd0) begin
                            pc_inc    = 1'b1;
                            state_nxt = S_FETCH;
                        end else begin
                            wait_load = 1'b1;
                            state_nxt = S_WAIT;
                        end
                    end
                    default: state_nxt = S_ERROR;
                endcase
            end
            S_WAIT: begin
                busy = 1'b1;
                if ((pre_cnt == 32'd0) && (wait_cnt == 10'd0)) begin
                    pc_inc    = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: pc, instruction register, valve bank and delay counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= START_ADDR;
            ir       <= '0;
            valves   <= '0;
            wait_cnt <= '0;
            pre_cnt  <= '0;
        end else begin
            if (pc_load) begin
                pc <= START_ADDR;
            end else if (pc_inc) begin
                pc <= pc + 8'd1;
            end
            if (ir_load) begin
                ir <= inst_data;
            end
            if (valve_wr) begin
                valves[ir_idx] <= ir_val;
            end
            // Loading N-1 ticks with a full prescaler period gives exactly
            // N periods of WAIT before the exit cycle returns to FETCH.
            if (wait_load) begin
                wait_cnt <= ir_cnt - 10'd1;
                pre_cnt  <= pre_reload;
            end else if (state == S_WAIT) begin
                if (pre_cnt != 32'd0) begin
                    pre_cnt <= pre_cnt - 32'd1;
                end else if (wait_cnt != 10'd0) begin
                    wait_cnt <= wait_cnt - 10'd1;
                    pre_cnt  <= pre_reload;
                end
            end
        end
    end

endmodule

// File: tb/tb_valve_sequencer.sv
// tb_valve_sequencer: program-driven scoreboard bench for valve_sequencer.
// Two instances share clock and reset: one with START_ADDR=1 and one with
// START_ADDR=255 for the pc wrap case. Both use CLKS_PER_MS=10.
module tb_valve_sequencer;

    localparam int LIMIT = 3000;

    logic        clk;
    logic        rst_n;
    logic        start_a;
    logic        start_b;
    logic [7:0]  inst_addr_a;
    logic [7:0]  inst_addr_b;
    logic [20:0] inst_data_a;
    logic [20:0] inst_data_b;
    logic [15:0] valves_a;
    logic [15:0] valves_b;
    logic        busy_a, busy_b, done_a, done_b, error_a, error_b;

    logic [20:0] mem_a [256];
    logic [20:0] mem_b [256];
    logic        sel;

    logic [15:0] obs_valves;
    logic [7:0]  obs_addr;
    logic        obs_busy, obs_done, obs_error;

    int n_chk;
    int n_err;

    typedef struct {
        string       tag;
        logic [7:0]  start_addr;
        int          cycles;
        logic [15:0] valves;
        logic [7:0]  addr;
        logic        done;
        logic        error;
        int          rise;
        int          hi;
    } exp_t;

    exp_t sbq[$];

    assign inst_data_a = mem_a[inst_addr_a];
    assign inst_data_b = mem_b[inst_addr_b];

    assign obs_valves = sel ? valves_b    : valves_a;
    assign obs_addr   = sel ? inst_addr_b : inst_addr_a;
    assign obs_busy   = sel ? busy_b      : busy_a;
    assign obs_done   = sel ? done_b      : done_a;
    assign obs_error  = sel ? error_b     : error_a;

    valve_sequencer #(.CLKS_PER_MS(10), .START_ADDR(8'd1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a),
        .inst_addr(inst_addr_a), .inst_data(inst_data_a),
        .valves(valves_a), .busy(busy_a), .done(done_a), .error(error_a)
    );

    valve_sequencer #(.CLKS_PER_MS(10), .START_ADDR(8'd255)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .inst_addr(inst_addr_b), .inst_data(inst_data_b),
        .valves(valves_b), .busy(busy_b), .done(done_b), .error(error_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [20:0] f_set(input logic [3:0] idx, input logic val);
        return {3'b001, idx, 13'd0, val};
    endfunction

    function automatic logic [20:0] f_delay(input logic [9:0] cnt, input logic [2:0] unit);
        return {3'b010, 4'd0, cnt, unit, 1'b0};
    endfunction

    function automatic logic [20:0] f_halt();
        return 21'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic expect_run(input string tag, input logic [7:0] sa, input int cyc,
                              input logic [15:0] v, input logic [7:0] addr,
                              input logic d, input logic er, input int rise, input int hi);
        exp_t e;
        e.tag = tag; e.start_addr = sa; e.cycles = cyc; e.valves = v; e.addr = addr;
        e.done = d; e.error = er; e.rise = rise; e.hi = hi;
        sbq.push_back(e);
    endtask

    // Pulse start, follow the run until done/error, then score it.
    // bit_idx: valve bit whose first-high sample and high count are tracked.
    // stray_n: sample index after which an extra start pulse is driven (-1: none).
    task automatic run_prog(input int bit_idx, input int stray_n);
        exp_t e;
        int   n;
        int   hi;
        int   rise;
        logic [7:0] addr0;
        logic       busy0;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
        addr0 = obs_addr;
        busy0 = obs_busy;
        n = 0; hi = 0; rise = -1;
        while (n < LIMIT) begin
            if (obs_valves[bit_idx]) begin
                hi++;
                if (rise < 0) rise = n;
            end
            if (obs_done || obs_error) break;
            if (n == stray_n) begin
                if (sel) start_b = 1'b1; else start_a = 1'b1;
            end
            @(posedge clk); #1;
            start_a = 1'b0; start_b = 1'b0;
            n++;
        end
        e = sbq.pop_front();
        chk({e.tag, "_start_addr"}, addr0, e.start_addr);
        chk({e.tag, "_start_busy"}, busy0, 1);
        chk({e.tag, "_finished"}, obs_done | obs_error, 1);
        chk({e.tag, "_cycles"}, n, e.cycles);
        chk({e.tag, "_valves"}, obs_valves, e.valves);
        chk({e.tag, "_addr"}, obs_addr, e.addr);
        chk({e.tag, "_done"}, obs_done, e.done);
        chk({e.tag, "_error"}, obs_error, e.error);
        chk({e.tag, "_busy"}, obs_busy, 0);
        chk({e.tag, "_rise"}, rise, e.rise);
        chk({e.tag, "_hi"}, hi, e.hi);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_err = 0;
        sel = 1'b0;
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 21'd0;
            mem_b[i] = 21'd0;
        end

        // Reset state of both instances.
        #12;
        chk("rst_valves_a", valves_a, 0);
        chk("rst_addr_a", inst_addr_a, 1);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_done_a", done_a, 0);
        chk("rst_error_a", error_a, 0);
        chk("rst_addr_b", inst_addr_b, 255);
        chk("rst_valves_b", valves_b, 0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_busy", busy_a, 0);
        chk("idle_done", done_a, 0);
        chk("idle_addr", inst_addr_a, 1);

        // SET v1, DELAY 2 ms, clear v1, HALT: v1 high 24 cycles.
        mem_a[1] = f_set(4'd1, 1'b1);
        mem_a[2] = f_delay(10'd2, 3'b001);
        mem_a[3] = f_set(4'd1, 1'b0);
        mem_a[4] = f_halt();
        expect_run("ms_delay", 8'd1, 28, 16'h0000, 8'd4, 1'b1, 1'b0, 2, 24);
        run_prog(1, -1);

        // Zero-count DELAY falls straight through to the next SET.
        mem_a[1] = f_delay(10'd0, 3'b000);
        mem_a[2] = f_set(4'd3, 1'b1);
        mem_a[3] = f_halt();
        expect_run("zero_delay", 8'd1, 6, 16'h0008, 8'd3, 1'b1, 1'b0, 4, 3);
        run_prog(3, -1);

        // Illegal opcode at address 2 stops with pc held there.
        mem_a[1] = f_set(4'd5, 1'b1);
        mem_a[2] = {3'b101, 18'd0};
        expect_run("bad_op", 8'd1, 4, 16'h0028, 8'd2, 1'b0, 1'b1, 2, 3);
        run_prog(5, -1);

        // Asynchronous reset in the middle of a 5 ms WAIT.
        mem_a[1] = f_set(4'd3, 1'b0);
        mem_a[2] = f_set(4'd5, 1'b0);
        mem_a[3] = f_set(4'd1, 1'b1);
        mem_a[4] = f_delay(10'd5, 3'b001);
        mem_a[5] = f_halt();
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        chk("restart_addr", inst_addr_a, 1);
        repeat (15) @(posedge clk);
        #1;
        chk("midwait_busy", busy_a, 1);
        chk("midwait_valves", valves_a, 16'h0002);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_valves", valves_a, 0);
        chk("async_busy", busy_a, 0);
        chk("async_error", error_a, 0);
        chk("async_addr", inst_addr_a, 1);
        @(posedge clk); #3;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_busy", busy_a, 0);
        chk("post_rst_addr", inst_addr_a, 1);
        expect_run("rerun", 8'd1, 60, 16'h0002, 8'd5, 1'b1, 1'b0, 6, 55);
        run_prog(1, -1);

        // Stray start during a 7-cycle WAIT leaves the timing alone.
        mem_a[1] = f_delay(10'd7, 3'b000);
        mem_a[2] = f_set(4'd2, 1'b1);
        mem_a[3] = f_halt();
        expect_run("stray_start", 8'd1, 13, 16'h0006, 8'd3, 1'b1, 1'b0, 11, 3);
        run_prog(2, 5);

        // DELAY with an illegal unit errors with pc unchanged.
        mem_a[1] = f_delay(10'd3, 3'b010);
        expect_run("bad_unit", 8'd1, 2, 16'h0006, 8'd1, 1'b0, 1'b1, 0, 3);
        run_prog(2, -1);

        // pc wraps 255 -> 0 on the second instance.
        sel = 1'b1;
        mem_b[255] = f_set(4'd0, 1'b1);
        mem_b[0]   = f_halt();
        expect_run("pc_wrap", 8'd255, 4, 16'h0001, 8'd0, 1'b1, 1'b0, 2, 3);
        run_prog(0, -1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
